pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline stage register; successor to the fixed, always-loading stage registers between execute and memory.
- Carries one packed payload of PAYLOAD_W bits with a valid/ready handshake on both sides.
- Supports stall (back-pressure), flush (bubble insertion) and an optional skid entry that breaks the combinational ready path.
- Instantiated between any two core stages (F/D, D/E, E/M); control fields such as reg_write and mem_access ride in the payload and are qualified by out_valid downstream.

Parameters:
- PAYLOAD_W, 32, width of in_data/out_data in bits (1..512).
- SKID, 1, 1 = two-entry buffer with registered in_ready; 0 = single entry with combinational in_ready.
- RESET_DATA, 0, value loaded into all payload storage on reset (PAYLOAD_W bits, zero-extended).

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, discard all held and incoming entries this cycle.
- in_valid, input, 1, upstream offers in_data.
- in_ready, output, 1, stage accepts in_data this cycle.
- in_data, input, PAYLOAD_W, payload from upstream stage.
- out_valid, output, 1, out_data holds a live entry.
- out_ready, input, 1, downstream consumes out_data this cycle.
- out_data, output, PAYLOAD_W, payload to downstream stage.
- occupancy, output, 2, number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Accept = in_valid & in_ready & ~flush. Consume = out_valid & out_ready.
- Reset: on a clk edge with rst=1, all valid bits clear and all payload storage loads RESET_DATA. out_valid=0 and occupancy=0 from the next cycle on. rst overrides flush and any handshake; reset mid-transfer drops the entry silently.
- Latency: an accepted entry appears on out_data/out_valid the cycle after acceptance. There is no combinational in_data->out_data path.
- Order: strict FIFO, with no duplication and no loss except by flush or reset.
- SKID=0:
  - One register with valid bit v.
  - in_ready = ~v | out_ready (combinational).
  - On accept, load the register and set v.
  - On consume without accept, clear v.
  - On simultaneous consume and accept, load the new entry and keep v=1.
- SKID=1:
  - Main entry M (drives out_*) plus skid entry S.
  - in_ready = ~S.valid, driven directly from a flop.
  - State machine with three states:
    - EMPTY (0 entries): accept -> ONE.
    - ONE (M valid): accept & ~consume -> TWO, new entry into S. Accept & consume -> ONE, new entry into M. Consume only -> EMPTY.
    - TWO (M,S valid, in_ready=0): consume -> ONE with S moved to M. Otherwise hold.
  - Full: in TWO, in_ready=0 and in_data is ignored. Empty: out_valid=0 and out_data holds its last value (don't-care to consumers).
- Flush:
  - At the next edge all valid bits clear, giving state EMPTY and occupancy 0.
  - in_valid in the flush cycle is not accepted, even if in_ready=1.
  - A consume in the flush cycle still counts as completed downstream.
  - Payload storage is not cleared by flush.
  - Flush and rst together: reset behaviour applies.
- in_ready and out_valid depend only on state (SKID=1); out_ready never propagates to in_ready in SKID=1.
- occupancy is registered and equals the number of valid bits set.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, occupancy=0, out_data=RESET_DATA (0), in_ready=1 after release.
- Streaming, SKID=1: in_valid=1, out_ready=1 every cycle, data 1,2,3,...,10 -> out_data shows 1..10 on consecutive cycles starting one cycle after first accept; occupancy stays 1; no gaps.
- Back-pressure: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, 0xC held off upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss or duplicate.
- Flush in TWO state with in_valid=1, in_data=0x55 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x55 never appears at output.
- SKID=0, full with out_ready=1 and in_valid=1 same cycle -> in_ready=1 combinationally, the old entry is consumed and the new one is loaded, occupancy stays 1.
- rst asserted while occupancy=2 and out_ready=1 -> next cycle out_valid=0, occupancy=0; neither held entry appears afterward.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with a valid/ready handshake on both sides.
// It supports stall, flush and an optional skid entry. With SKID=1 the stage
// holds two entries, and in_ready comes straight from a flop, so downstream
// ready never reaches upstream combinationally. With SKID=0 the stage holds a
// single entry, and in_ready is combinational.
module pipe_stage_elastic #(
    parameter int unsigned          PAYLOAD_W  = 32,
    parameter bit                   SKID       = 1'b1,
    parameter logic [PAYLOAD_W-1:0] RESET_DATA = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o,
    output logic [1:0]           occupancy_o
);

    logic accept;
    logic consume;

    assign accept  = in_valid_i & in_ready_o & ~flush_i;
    assign consume = out_valid_o & out_ready_i;

    if (SKID) begin : g_skid
        typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

        state_e                 state_q, state_d;
        logic [PAYLOAD_W-1:0]   m_data_q, m_data_d;
        logic [PAYLOAD_W-1:0]   s_data_q, s_data_d;
        logic                   in_ready_q, in_ready_d;
        logic [1:0]             occ_q, occ_d;

        // Next-state: entry movement between upstream, main (M) and skid (S)
        always_comb begin
            state_d  = state_q;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        m_data_d = in_data_i;
                        state_d  = StOne;
                    end
                end
                StOne: begin
                    if (accept && !consume) begin
                        s_data_d = in_data_i;
                        state_d  = StTwo;
                    end else if (accept && consume) begin
                        m_data_d = in_data_i;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (consume) begin
                        m_data_d = s_data_q;
                        state_d  = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
            // Flush drops validity only; payload storage keeps whatever it held
            if (flush_i) begin
                state_d = StEmpty;
            end
            in_ready_d = (state_d != StTwo);
            occ_d      = (state_d == StTwo) ? 2'd2 : (state_d == StOne) ? 2'd1 : 2'd0;
        end

        // State, payload, and registered in_ready/occupancy
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q    <= StEmpty;
                m_data_q   <= RESET_DATA;
                s_data_q   <= RESET_DATA;
                in_ready_q <= 1'b1;
                occ_q      <= 2'd0;
            end else begin
                state_q    <= state_d;
                m_data_q   <= m_data_d;
                s_data_q   <= s_data_d;
                in_ready_q <= in_ready_d;
                occ_q      <= occ_d;
            end
        end

        assign in_ready_o  = in_ready_q;
        assign out_valid_o = (state_q != StEmpty);
        assign out_data_o  = m_data_q;
        assign occupancy_o = occ_q;
    end else begin : g_noskid
        logic                 v_q, v_d;
        logic [PAYLOAD_W-1:0] data_q;

        // Valid bit: flush wins, then load, then drain
        always_comb begin
            v_d = v_q;
            if (flush_i) begin
                v_d = 1'b0;
            end else if (accept) begin
                v_d = 1'b1;
            end else if (consume) begin
                v_d = 1'b0;
            end
        end

        // Single entry register; loads on every accept
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q    <= 1'b0;
                data_q <= RESET_DATA;
            end else begin
                v_q <= v_d;
                if (accept) begin
                    data_q <= in_data_i;
                end
            end
        end

        assign in_ready_o  = ~v_q | out_ready_i;
        assign out_valid_o = v_q;
        assign out_data_o  = data_q;
        assign occupancy_o = {1'b0, v_q};
    end

endmodule
